mlp_layer_engine: RTL and testbench
===================================

// Module: mlp_layer_engine
// PURPOSE
//  Parametrised, time-multiplexed fully-connected layer for the drowsiness-detector MLP.
//  Computes N_NEU neurons over N_IN inputs with one signed MAC, streaming weights/bias from external RAM.
//  Start/done handshake, per-run activation select; two instances chain hidden->output (done -> start).
// PARAMETERS
//  N_IN   10  inputs per neuron
//  N_NEU  5   neurons in this layer
//  DW     10  signed fixed-point data/weight width
//  FRAC   6   fractional bits (1.0 = 1<<FRAC = 64)
//  AW     $clog2(N_NEU*(N_IN+1))  weight address width (derived)
// PORTS
//  Clock     in   1         rising-edge clock
//  Rst       in   1         asynchronous, active-low reset
//  start     in   1         run request; sampled only in IDLE
//  act_mode  in   2         0 linear, 1 ReLU, 2 hard-sigmoid, 3 = linear; captured at start
//  in_vec    in   N_IN*DW   signed inputs, element i at [i*DW +: DW]; captured at start
//  w_rd      out  1         weight RAM read strobe
//  w_addr    out  AW        weight RAM address
//  w_data    in   DW        signed weight/bias; valid exactly 1 cycle after w_rd
//  busy      out  1         high from start acceptance until done
//  done      out  1         1-cycle pulse, run complete
//  out_vec   out  N_NEU*DW  signed results, neuron j at [j*DW +: DW]
//  out_valid out  1         out_vec holds a complete run result
// BEHAVIOUR
//  Reset: state IDLE; busy, done, w_rd, out_valid = 0; w_addr, out_vec, accumulator = 0.
//  Weight layout: neuron j row base j*(N_IN+1); offsets 0..N_IN-1 weights, offset N_IN bias.
//  FSM IDLE -> READ -> DRAIN -> WRITE -> (READ next neuron | DONE) -> IDLE.
//   IDLE: start=1 captures in_vec/act_mode, clears acc, out_valid=0, busy=1, -> READ (j=0).
//   READ: N_IN+1 cycles, w_rd=1, w_addr = base..base+N_IN contiguous; acc updates 1 cycle after each read.
//   DRAIN: w_rd=0; last returned word (bias) added as bias<<<FRAC.
//   WRITE: out_vec[j] <= act(sat(acc>>>FRAC)); acc cleared; j==N_NEU-1 -> DONE else READ.
//   DONE: done=1, out_valid=1, busy=0 -> IDLE next cycle.
//  Timing: N_IN+3 cycles per neuron; done high N_NEU*(N_IN+3)+1 cycles after start-sampling edge (66 default).
//  Arithmetic: products 2*DW signed; acc width 2*DW+$clog2(N_IN+1), no overflow possible.
//   Rescale: arithmetic shift right FRAC (floor); saturate to [-2^(DW-1), 2^(DW-1)-1].
//   ReLU: negative -> 0. Hard-sigmoid: clamp((y>>>2) + (1<<(FRAC-1)), 0, 1<<FRAC).
//  Boundaries: start ignored while busy or in DONE; in_vec/act_mode changes during a run ignored;
//   out_vec[j] for j not yet rewritten holds previous run's value (out_valid=0 flags it);
//   w_data ignored except 1 cycle after w_rd; Rst low mid-run aborts immediately to reset values.
// STRUCTURE
//  Package mlp_pkg: state enum, act_mode enum (ACT_LIN/ACT_RELU/ACT_HSIG), default DW/FRAC,
//   saturate and hard-sigmoid functions shared by all layer instances.
//  One sub-module: mlp_mac_sat (acc clear/accumulate/bias-add, rescale, saturate, activation).
//  Top holds FSM, neuron/input counters, address generator, input/output registers.
// TESTING (defaults N_IN=10, N_NEU=5, DW=10, FRAC=6)
//  All in=64, all weights=32, bias=0, linear -> every out=320; done at cycle 66; w_addr 0..54 in order.
//  in=127, weights=127, bias=127, linear -> every out=511 (positive saturation); weights=-127 -> -512.
//  in=64, weights=-32, ReLU -> out=0; same with weights=+32 -> 320.
//  Hard-sigmoid: neuron sums 0, 5.0 (320), -5.0 -> outs 32, 64, 0; bias-only row 64 -> (64>>>2)+32=48.
//  start pulsed at cycles 5 and 40 of a run -> ignored, single done; Rst low at cycle 30 -> all outputs 0, IDLE.
//  Back-to-back: start in cycle after done -> accepted, out_valid drops, new results differ correctly.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed MLP layer engine.
package mlp_pkg;

  localparam int DW_DEF   = 10;
  localparam int FRAC_DEF = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ACT_LIN  = 2'd0,
    ACT_RELU = 2'd1,
    ACT_HSIG = 2'd2,
    ACT_LIN3 = 2'd3
  } act_t;

  function automatic longint sat_val(longint v, int unsigned dw);
    longint hi, lo;
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Piecewise-linear sigmoid: slope 1/4, centred on 0.5, clamped to [0, 1.0].
  function automatic longint hsig(longint y, int unsigned frac);
    longint one, t;
    one = longint'(1) <<< frac;
    t   = (y >>> 2) + (one >>> 1);
    if (t < 0)   return 0;
    if (t > one) return one;
    return t;
  endfunction

endpackage

// File: rtl/mlp_mac_sat.sv
// Signed multiply-accumulate with bias add, fixed-point rescale, saturation and activation.
module mlp_mac_sat
  import mlp_pkg::*;
#(
  parameter int N_IN = 10,
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                 Clock,
  input  logic                 Rst,
  input  logic                 clr,
  input  logic                 mac_en,
  input  logic                 bias_en,
  input  logic [1:0]           act,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] w,
  output logic signed [DW-1:0] y
);

  localparam int ACCW = 2 * DW + $clog2(N_IN + 1);

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] acc, prod_x, bias_x, shifted;
  longint                 s, r;

  assign prod   = x * w;
  assign prod_x = {{(ACCW - 2 * DW){prod[2*DW-1]}}, prod};
  // Bias is stored in the same Q format as the inputs, so align it with the products.
  assign bias_x = {{(ACCW - DW){w[DW-1]}}, w} <<< FRAC;

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst)         acc <= '0;
    else if (clr)     acc <= '0;
    else if (mac_en)  acc <= acc + prod_x;
    else if (bias_en) acc <= acc + bias_x;
  end

  always_comb begin
    shifted = acc >>> FRAC;
    s       = sat_val(longint'(shifted), DW);
    r       = s;
    case (act_t'(act))
      ACT_RELU: r = (s < 0) ? 0 : s;
      ACT_HSIG: r = hsig(s, FRAC);
      default:  r = s;
    endcase
    y = DW'(r);
  end

endmodule

// File: rtl/mlp_layer_engine.sv
// Fully-connected layer: one shared MAC walks N_NEU neurons, streaming weight rows from external RAM.
module mlp_layer_engine
  import mlp_pkg::*;
#(
  parameter int N_IN  = 10,
  parameter int N_NEU = 5,
  parameter int DW    = DW_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int AW    = $clog2(N_NEU * (N_IN + 1))
) (
  input  logic                Clock,
  input  logic                Rst,
  input  logic                start,
  input  logic [1:0]          act_mode,
  input  logic [N_IN*DW-1:0]  in_vec,
  output logic                w_rd,
  output logic [AW-1:0]       w_addr,
  input  logic [DW-1:0]       w_data,
  output logic                busy,
  output logic                done,
  output logic [N_NEU*DW-1:0] out_vec,
  output logic                out_valid
);

  localparam int CW = $clog2(N_IN + 1);
  localparam int NW = (N_NEU > 1) ? $clog2(N_NEU) : 1;

  state_t               state, nxt;
  logic [CW-1:0]        rcnt, xi;
  logic [NW-1:0]        ncnt;
  logic [1:0]           act_q;
  logic signed [DW-1:0] x_q [N_IN];
  logic signed [DW-1:0] x_sel, y;
  logic                 acc_clr, mac_en, bias_en;

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt  = state;
    w_rd = 1'b0;
    case (state)
      S_IDLE:  if (start) nxt = S_READ;
      S_READ: begin
        w_rd = 1'b1;
        if (rcnt == CW'(N_IN)) nxt = S_DRAIN;
      end
      S_DRAIN: nxt = S_WRITE;
      S_WRITE: nxt = (ncnt == NW'(N_NEU - 1)) ? S_DONE : S_READ;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Word read at rcnt arrives one cycle later, so the MAC consumes input rcnt-1.
  assign xi      = rcnt - CW'(1);
  assign mac_en  = (state == S_READ) && (rcnt != '0);
  assign bias_en = (state == S_DRAIN);
  assign acc_clr = ((state == S_IDLE) && start) || (state == S_WRITE);
  assign x_sel   = mac_en ? x_q[xi] : '0;

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      w_addr    <= '0;
      rcnt      <= '0;
      ncnt      <= '0;
      act_q     <= '0;
      out_vec   <= '0;
      for (int unsigned i = 0; i < N_IN; i++) x_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          busy      <= 1'b1;
          out_valid <= 1'b0;
          act_q     <= act_mode;
          w_addr    <= '0;
          rcnt      <= '0;
          ncnt      <= '0;
          for (int unsigned i = 0; i < N_IN; i++) x_q[i] <= in_vec[i*DW +: DW];
        end
        // Rows are contiguous, so the address simply keeps counting across neurons.
        S_READ: begin
          w_addr <= w_addr + AW'(1);
          rcnt   <= (rcnt == CW'(N_IN)) ? '0 : rcnt + CW'(1);
        end
        S_WRITE: begin
          out_vec[int'(ncnt)*DW +: DW] <= y;
          ncnt <= ncnt + NW'(1);
        end
        S_DONE: begin
          done      <= 1'b1;
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  mlp_mac_sat #(
    .N_IN (N_IN),
    .DW   (DW),
    .FRAC (FRAC)
  ) u_mac (
    .Clock   (Clock),
    .Rst     (Rst),
    .clr     (acc_clr),
    .mac_en  (mac_en),
    .bias_en (bias_en),
    .act     (act_q),
    .x       (x_sel),
    .w       (w_data),
    .y       (y)
  );

endmodule

// File: tb/tb_mlp_layer_engine.sv
// Directed self-checking bench for mlp_layer_engine with a behavioural weight RAM.
module tb_mlp_layer_engine;

  localparam int N_IN  = 10;
  localparam int N_NEU = 5;
  localparam int DW    = 10;
  localparam int NW    = N_NEU * (N_IN + 1);

  logic                Clock = 1'b0;
  logic                Rst;
  logic                start;
  logic [1:0]          act_mode;
  logic [N_IN*DW-1:0]  in_vec;
  logic                w_rd;
  logic [5:0]          w_addr;
  logic [DW-1:0]       w_data;
  logic                busy, done, out_valid;
  logic [N_NEU*DW-1:0] out_vec;

  logic signed [DW-1:0] mem [NW];
  int                   addr_log[$];
  logic                 log_en = 1'b0;
  int                   checks = 0;
  int                   errors = 0;

  always #5 Clock = ~Clock;

  // RAM returns data one cycle after the strobe; otherwise drives junk the DUT must ignore.
  always @(posedge Clock) begin
    if (w_rd && (int'(w_addr) < NW)) w_data <= mem[w_addr];
    else                             w_data <= DW'($urandom);
    if (w_rd && log_en) addr_log.push_back(int'(w_addr));
  end

  mlp_layer_engine #(
    .N_IN  (N_IN),
    .N_NEU (N_NEU),
    .DW    (DW),
    .FRAC  (6)
  ) dut (
    .Clock     (Clock),
    .Rst       (Rst),
    .start     (start),
    .act_mode  (act_mode),
    .in_vec    (in_vec),
    .w_rd      (w_rd),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .busy      (busy),
    .done      (done),
    .out_vec   (out_vec),
    .out_valid (out_valid)
  );

  function automatic logic signed [DW-1:0] outj(int j);
    return out_vec[j*DW +: DW];
  endfunction

  task automatic set_inputs(input int v);
    for (int i = 0; i < N_IN; i++) in_vec[i*DW +: DW] = DW'(v);
  endtask

  task automatic set_row(input int j, input int w, input int b);
    for (int i = 0; i < N_IN; i++) mem[j*(N_IN+1) + i] = DW'(w);
    mem[j*(N_IN+1) + N_IN] = DW'(b);
  endtask

  task automatic fill(input int w, input int b);
    for (int j = 0; j < N_NEU; j++) set_row(j, w, b);
  endtask

  // Returns at the negedge right after the edge that samples start.
  task automatic start_run(input logic [1:0] am);
    @(negedge Clock);
    act_mode = am;
    start    = 1'b1;
    @(negedge Clock);
    start    = 1'b0;
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!done && cyc < 300) begin
      @(negedge Clock);
      cyc++;
    end
  endtask

  task automatic test_reset;
    Rst = 1'b0; start = 1'b0; act_mode = '0; in_vec = '0;
    repeat (2) @(negedge Clock);
    checks++;
    if ({busy, done, w_rd, out_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, w_rd, out_valid});
    end
    checks++;
    if (out_vec !== '0 || w_addr !== '0) begin
      errors++; $display("FAIL reset_data out_vec=%h w_addr=%0d exp 0/0", out_vec, w_addr);
    end
    Rst = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_linear;
    int cyc;
    set_inputs(64); fill(32, 0);
    addr_log.delete(); log_en = 1'b1;
    start_run(2'd0);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL lin_accept busy=%b out_valid=%b exp 1/0", busy, out_valid);
    end
    wait_done(0, cyc);
    log_en = 1'b0;
    checks++;
    if (cyc !== 66) begin errors++; $display("FAIL lin_done_cycle got=%0d exp=66", cyc); end
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL lin_done_flags out_valid=%b busy=%b exp 1/0", out_valid, busy);
    end
    for (int j = 0; j < N_NEU; j++) begin
      checks++;
      if (outj(j) !== 10'sd320) begin errors++; $display("FAIL lin_out%0d got=%0d exp=320", j, outj(j)); end
    end
    checks++;
    if (addr_log.size() !== NW) begin
      errors++; $display("FAIL lin_addr_count got=%0d exp=%0d", addr_log.size(), NW);
    end else begin
      for (int i = 0; i < NW; i++) begin
        checks++;
        if (addr_log[i] !== i) begin errors++; $display("FAIL lin_addr%0d got=%0d exp=%0d", i, addr_log[i], i); end
      end
    end
    @(negedge Clock);
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL lin_done_pulse done=%b out_valid=%b exp 0/1", done, out_valid);
    end
  endtask

  task automatic test_saturation;
    int cyc;
    set_inputs(127); fill(127, 127);
    start_run(2'd0); wait_done(0, cyc);
    for (int j = 0; j < N_NEU; j++) begin
      checks++;
      if (outj(j) !== 10'sd511) begin errors++; $display("FAIL sat_pos%0d got=%0d exp=511", j, outj(j)); end
    end
    fill(-127, -127);
    start_run(2'd3); wait_done(0, cyc);
    for (int j = 0; j < N_NEU; j++) begin
      checks++;
      if (outj(j) !== -10'sd512) begin errors++; $display("FAIL sat_neg%0d got=%0d exp=-512", j, outj(j)); end
    end
  endtask

  task automatic test_relu;
    int cyc;
    set_inputs(64); fill(-32, 0);
    start_run(2'd1); wait_done(0, cyc);
    for (int j = 0; j < N_NEU; j++) begin
      checks++;
      if (outj(j) !== 10'sd0) begin errors++; $display("FAIL relu_neg%0d got=%0d exp=0", j, outj(j)); end
    end
    fill(32, 0);
    start_run(2'd1); wait_done(0, cyc);
    for (int j = 0; j < N_NEU; j++) begin
      checks++;
      if (outj(j) !== 10'sd320) begin errors++; $display("FAIL relu_pos%0d got=%0d exp=320", j, outj(j)); end
    end
  endtask

  task automatic test_hsig;
    int cyc;
    int exp_v [N_NEU] = '{32, 64, 0, 48, 29};
    set_inputs(64);
    set_row(0, 0, 0);     // y = 0
    set_row(1, 32, 0);    // y = 320
    set_row(2, -32, 0);   // y = -320
    set_row(3, 0, 64);    // y = 64
    set_row(4, -1, 0);    // y = -10, floor(-10/4) = -3
    start_run(2'd2); wait_done(0, cyc);
    for (int j = 0; j < N_NEU; j++) begin
      checks++;
      if (outj(j) !== DW'(exp_v[j])) begin errors++; $display("FAIL hsig_out%0d got=%0d exp=%0d", j, outj(j), exp_v[j]); end
    end
  endtask

  task automatic test_floor;
    int cyc;
    int w0 [N_NEU] = '{1, -1, 100, -100, 0};
    int exp_v [N_NEU] = '{0, -1, 1, -2, 0};
    set_inputs(0);
    in_vec[0 +: DW] = DW'(1);
    fill(50, 0);
    for (int j = 0; j < N_NEU; j++) mem[j*(N_IN+1)] = DW'(w0[j]);
    start_run(2'd0); wait_done(0, cyc);
    for (int j = 0; j < N_NEU; j++) begin
      checks++;
      if (outj(j) !== DW'(exp_v[j])) begin errors++; $display("FAIL floor_out%0d got=%0d exp=%0d", j, outj(j), exp_v[j]); end
    end
  endtask

  task automatic test_start_ignored;
    int ndone = 0;
    int first = -1;
    set_inputs(64); fill(32, 0);
    start_run(2'd0);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge Clock);
      if (done) begin
        ndone++;
        if (first < 0) first = cyc;
      end
      start = (cyc == 5 || cyc == 40);
      if (cyc == 5) begin set_inputs(127); act_mode = 2'd2; end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1 || first !== 66) begin
      errors++; $display("FAIL ign_done count=%0d at=%0d exp 1 at 66", ndone, first);
    end
    for (int j = 0; j < N_NEU; j++) begin
      checks++;
      if (outj(j) !== 10'sd320) begin errors++; $display("FAIL ign_out%0d got=%0d exp=320", j, outj(j)); end
    end
  endtask

  task automatic test_abort;
    set_inputs(64); fill(32, 0);
    start_run(2'd0);
    repeat (29) @(negedge Clock);
    Rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, w_rd, out_valid} !== 4'b0000 || out_vec !== '0 || w_addr !== '0) begin
      errors++;
      $display("FAIL abort_reset flags=%b out_vec=%h w_addr=%0d exp 0000/0/0", {busy, done, w_rd, out_valid}, out_vec, w_addr);
    end
    @(negedge Clock);
    Rst = 1'b1;
    repeat (3) @(negedge Clock);
    checks++;
    if ({busy, done, w_rd} !== 3'b000) begin
      errors++; $display("FAIL abort_idle flags=%b exp=000", {busy, done, w_rd});
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int exp_v [N_NEU] = '{-80, -159, -238, -317, -396};
    set_inputs(64); fill(32, 0);
    start_run(2'd0); wait_done(0, cyc);
    set_inputs(-64);
    for (int j = 0; j < N_NEU; j++) set_row(j, 8 * (j + 1), j);
    start_run(2'd0);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept out_valid=%b busy=%b exp 0/1", out_valid, busy);
    end
    repeat (5) @(negedge Clock);
    checks++;
    if (outj(4) !== 10'sd320) begin errors++; $display("FAIL b2b_stale got=%0d exp=320", outj(4)); end
    wait_done(5, cyc);
    checks++;
    if (cyc !== 66) begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=66", cyc); end
    for (int j = 0; j < N_NEU; j++) begin
      checks++;
      if (outj(j) !== DW'(exp_v[j])) begin errors++; $display("FAIL b2b_out%0d got=%0d exp=%0d", j, outj(j), exp_v[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_saturation();
    test_relu();
    test_hsig();
    test_floor();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
